// File: rtl/regfile_param_pkg.sv
// rtl/regfile_param_pkg.sv - shared types and helpers for the parametrised register file
package regfile_param_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // Address width for a given depth, never below one bit.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential clear engine that zeroes one entry per cycle
module regfile_clear_fsm
  import regfile_param_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          // A fresh request restarts the sweep from entry 0.
          if (clear) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          if (clear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 1W/2R register file with bypass, zero register and clear engine
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdDataA,
  output logic [WIDTH-1:0]  rdDataB,
  output logic              busy,
  output logic              wrAck
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic              wr_accept;
  logic              zero_wr;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign busy      = clr_busy;
  assign zero_wr   = (ZERO_REG != 0) && (wrAddr == '0);
  // The write on a clear edge still lands; the sweep overwrites it later.
  assign wr_en     = write && !clr_busy && !zero_wr;
  assign wr_accept = write && !clr_busy && !clear;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrAck <= 1'b0;
    end else begin
      wrAck <= wr_accept;
    end
  end

  always_comb begin
    rdDataA = mem[rdAddrA];
    if (clr_busy || ((ZERO_REG != 0) && (rdAddrA == '0))) begin
      rdDataA = '0;
    end else if (write && !clear && (wrAddr == rdAddrA)) begin
      rdDataA = wrData;
    end
  end

  always_comb begin
    rdDataB = mem[rdAddrB];
    if (clr_busy || ((ZERO_REG != 0) && (rdAddrB == '0))) begin
      rdDataB = '0;
    end else if (write && !clear && (wrAddr == rdAddrB)) begin
      rdDataB = wrData;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (8x16, 8x16 zero-reg, 16x32)
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        write, clear;
  logic [2:0]  wr_addr, ra, rb;
  logic [15:0] wr_data;
  logic [15:0] a_rda, a_rdb, z_rda, z_rdb;
  logic        a_busy, a_ack, z_busy, z_ack;

  logic        w_write, w_clear;
  logic [3:0]  w_wr_addr, w_ra, w_rb;
  logic [31:0] w_wr_data, w_rda, w_rdb;
  logic        w_busy, w_ack;

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst(rst), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
    .clear(clear), .rdAddrA(ra), .rdAddrB(rb), .rdDataA(a_rda), .rdDataB(a_rdb),
    .busy(a_busy), .wrAck(a_ack));

  regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
    .clear(clear), .rdAddrA(ra), .rdAddrB(rb), .rdDataA(z_rda), .rdDataB(z_rdb),
    .busy(z_busy), .wrAck(z_ack));

  regfile_param #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0)) dut_w (
    .clk(clk), .rst(rst), .write(w_write), .wrAddr(w_wr_addr), .wrData(w_wr_data),
    .clear(w_clear), .rdAddrA(w_ra), .rdAddrB(w_rb), .rdDataA(w_rda), .rdDataB(w_rdb),
    .busy(w_busy), .wrAck(w_ack));

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t        vecs[11];
  int          n_pass = 0;
  int          n_total = 0;
  logic        exp_ack_q[$];
  logic [31:0] w_model[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic w, input logic c, input logic [2:0] a,
                       input logic [15:0] d, input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    write = w; clear = c; wr_addr = a; wr_data = d; ra = x; rb = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1);
  end

  initial begin
    logic        e;
    int          n;
    logic [3:0]  wa[4];
    logic [31:0] wd[4];

    vecs[0]  = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd1, 16'hFFFF, 16'h0000};
    vecs[1]  = '{1'b1, 3'd1, 16'hAAAA, 3'd0, 3'd1, 16'hFFFF, 16'hAAAA};
    vecs[2]  = '{1'b1, 3'd2, 16'hCCCC, 3'd2, 3'd1, 16'hCCCC, 16'hAAAA};
    vecs[3]  = '{1'b1, 3'd3, 16'hF0F0, 3'd2, 3'd3, 16'hCCCC, 16'hF0F0};
    vecs[4]  = '{1'b0, 3'd3, 16'h0000, 3'd2, 3'd3, 16'hCCCC, 16'hF0F0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF};
    vecs[6]  = '{1'b1, 3'd5, 16'h1234, 3'd4, 3'd5, 16'h0000, 16'h1234};
    vecs[7]  = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 16'hBEEF, 16'h0000};
    vecs[9]  = '{1'b1, 3'd0, 16'h5555, 3'd0, 3'd7, 16'h5555, 16'h0000};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd2, 16'h5555, 16'hCCCC};
    wa = '{4'd0, 4'd1, 4'd2, 4'd15};
    wd = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'hDEAD_BEEF};
    for (int i = 0; i < 16; i++) w_model[i] = '0;

    rst = 1'b1; write = 0; clear = 0; wr_addr = 0; wr_data = 0; ra = 0; rb = 0;
    w_write = 0; w_clear = 0; w_wr_addr = 0; w_wr_data = 0; w_ra = 0; w_rb = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 1'b1);
    chk("rst_ack", a_ack, 1'b0);
    chk("rst_rda", a_rda, 16'h0);
    chk("rst_rdb", a_rdb, 16'h0);
    chk("rst_z_busy", z_busy, 1'b1);
    chk("rst_w_busy", w_busy, 1'b1);

    @(negedge clk); rst = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_clear_edges", n, 8);

    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 3'(i), 3'(7 - i));
      #1;
      chk($sformatf("init_rda%0d", i), a_rda, 16'h0);
      chk($sformatf("init_rdb%0d", 7 - i), a_rdb, 16'h0);
    end

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wr, 0, vecs[i].addr, vecs[i].data, vecs[i].ra, vecs[i].rb);
      #1;
      chk($sformatf("vec%0d_rda", i), a_rda, vecs[i].exp_a);
      chk($sformatf("vec%0d_rdb", i), a_rdb, vecs[i].exp_b);
      chk($sformatf("vec%0d_z_rda", i), z_rda, (vecs[i].ra == 0) ? 16'h0 : vecs[i].exp_a);
      chk($sformatf("vec%0d_z_rdb", i), z_rdb, (vecs[i].rb == 0) ? 16'h0 : vecs[i].exp_b);
      exp_ack_q.push_back(vecs[i].wr);
      @(posedge clk); #1;
      e = exp_ack_q.pop_front();
      chk($sformatf("vec%0d_ack", i), a_ack, e);
      chk($sformatf("vec%0d_z_ack", i), z_ack, e);
    end

    // clear request in IDLE with a same-edge write, then a write while busy
    drive(1, 1, 6, 16'h7777, 6, 2);
    #1;
    chk("clr_edge_no_bypass", a_rda, 16'h0);
    chk("clr_edge_rdb", a_rdb, 16'hCCCC);
    exp_ack_q.push_back(1'b0);
    @(posedge clk); #1;
    chk("clr_busy_1edge", a_busy, 1'b1);
    chk("clr_edge_ack", a_ack, exp_ack_q.pop_front());
    drive(1, 0, 2, 16'h9999, 2, 2);
    #1;
    chk("clr_busy_read", a_rda, 16'h0);
    exp_ack_q.push_back(1'b0);
    @(posedge clk); #1;
    n = 1;
    chk("clr_drop_ack", a_ack, exp_ack_q.pop_front());
    drive(0, 0, 0, 0, 0, 0);
    while (a_busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_edges", n, 8);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 3'(i), 3'(7 - i));
      #1;
      chk($sformatf("clr_rda%0d", i), a_rda, 16'h0);
      chk($sformatf("clr_z_rdb%0d", 7 - i), z_rdb, 16'h0);
    end

    // rst mid-clear at clrCnt=4 restarts the full sweep
    drive(0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("mid_busy", a_busy, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_busy", a_busy, 1'b1);
    chk("mid_rst_ack", a_ack, 1'b0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (a_busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("mid_rst_edges", n, 8);
    while (w_busy && n < 40) begin @(posedge clk); #1; n++; end
    chk("w_clear_edges", n, 16);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_write = 1'b1; w_wr_addr = wa[i]; w_wr_data = wd[i]; w_ra = wa[i]; w_rb = 4'd15;
      #1;
      chk($sformatf("w%0d_bypass", i), w_rda, wd[i]);
      chk($sformatf("w%0d_rdb", i), w_rdb, (wa[i] == 4'd15) ? wd[i] : w_model[15]);
      exp_ack_q.push_back(1'b1);
      @(posedge clk); #1;
      chk($sformatf("w%0d_ack", i), w_ack, exp_ack_q.pop_front());
      w_model[wa[i]] = wd[i];
    end
    @(negedge clk);
    w_write = 1'b0; w_ra = 4'd2; w_rb = 4'd15;
    #1;
    chk("w_rda_2", w_rda, w_model[2]);
    chk("w_rdb_15", w_rdb, w_model[15]);
    exp_ack_q.push_back(1'b0);
    @(posedge clk); #1;
    chk("w_idle_ack", w_ack, exp_ack_q.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file, successor to the fixed 4x16 file: configurable word width and depth, one synchronous write port, two combinational read ports with same-cycle write-through bypass, optional hardwired-zero register 0, and a sequential clear engine that zeroes every entry after reset or on request. It is the operand store for the datapath, feeding the ALU A/B inputs and taking the writeback result.

## Interface
- WIDTH, 16: data word width in bits (≥1).
- DEPTH, 8: number of registers; power of two, ≥2.
- ADDR_W, $clog2(DEPTH): address width; derived, never overridden.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- write  in  1  write enable, sampled on the rising edge of clk.
- wrAddr  in  ADDR_W  write address.
- wrData  in  WIDTH  write data.
- clear  in  1  single-cycle request to zero the whole file.
- rdAddrA  in  ADDR_W  read address, port A.
- rdAddrB  in  ADDR_W  read address, port B.
- rdDataA  out  WIDTH  read data, port A (combinational).
- rdDataB  out  WIDTH  read data, port B (combinational).
- busy  out  1  clear engine active; file not usable.
- wrAck  out  1  registered pulse: previous cycle's write was accepted.

## Operation
- FSM states: CLEAR, IDLE. Clear counter clrCnt is ADDR_W bits.
- rst asserted: state=CLEAR, clrCnt=0, wrAck=0 immediately (async). Memory contents are not reset directly; the engine zeroes them.
- CLEAR: each edge writes 0 to entry clrCnt, clrCnt+1; on the edge where clrCnt=DEPTH-1 the write completes and state→IDLE. No wrap past DEPTH-1.
- IDLE: clear=1 on an edge → CLEAR with clrCnt=0 next cycle; the write on that same edge is still performed (it is overwritten later).
- clear=1 while in CLEAR: clrCnt restarts at 0.
- busy=1 exactly when state=CLEAR.
- Write accepted when write=1, state=IDLE and clear=0 on the rising edge; entry wrAddr ← wrData; wrAck=1 on the following cycle, else 0. Writes during CLEAR are dropped, wrAck=0.
- ZERO_REG=1 and wrAddr=0: accepted (wrAck=1) but storage unchanged.
- Read X ∈ {A,B}: if busy → 0; else if ZERO_REG=1 and rdAddrX=0 → 0; else if write=1, clear=0 and wrAddr=rdAddrX → wrData (bypass); else stored entry.
- Both read ports may address the same entry; both return the same value.

## Timing
- Reset values: busy=1, wrAck=0, rdDataA=rdDataB=0.
- After rst deasserts, busy stays high for exactly DEPTH rising edges, then drops; first write accepted on the next edge.
- Write latency: stored on edge N, visible via storage from edge N; visible via bypass combinationally in cycle N-1 (same cycle as write).
- clear request to busy high: 1 edge. Clear duration: DEPTH edges.
- rst mid-clear or mid-write: async abort, restart from clrCnt=0.

## Structure
- Shared package: ADDR_W derivation function, FSM state enum (CLEAR, IDLE).
- One sub-module: regfile_clear_fsm (state, clrCnt, busy, clear write enable/address); top holds storage array, write mux, bypass read muxes, wrAck flop.

## Test plan
- Reset with WIDTH=16, DEPTH=8: rst high 3 cycles → busy=1, wrAck=0, reads 0; after release busy high 8 edges then 0; all entries read 0x0000.
- Write 0xFFFF@0, 0xAAAA@1, 0xCCCC@2, 0xF0F0@3, one per cycle → wrAck pulses each next cycle; rdAddrA=2, rdAddrB=3 → 0xCCCC, 0xF0F0.
- Bypass: entry 5=0x1234, write=1 wrAddr=5 wrData=0xBEEF, rdAddrA=5 same cycle → rdDataA=0xBEEF before the edge, 0xBEEF after.
- ZERO_REG=1: write 0x5555@0 → wrAck=1, rdDataA(addr 0)=0 including bypass cycle.
- clear pulse in IDLE with file populated → busy next edge for 8 edges; write attempted during busy dropped, wrAck=0; afterwards all reads 0.
- rst asserted mid-clear at clrCnt=4 → busy stays 1, full 8-edge clear after release; DEPTH=16, WIDTH=32 rerun of scenario 2 with 0xDEADBEEF@15.
